alu_ctrl_seq: RTL and testbench

Registered, parametrised successor to the combinational ALU control decoder. It decodes opcode/Funct3/Funct7 into an ALU op class plus explicit mode bits, with a valid/ready handshake on both sides. It also sequences multi-cycle MUL/DIV ops through a request/done handshake with a timeout counter. It sits between the decode stage and the execute stage, and drives the ALU and the mul/div unit.

---
 rtl/alu_ctrl_seq.sv | 266 ++++++++++++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decoder with valid/ready handshakes and a
// mul/div sequencer (request/done with timeout abort).
//
// Optional feature macro: M_EXT_EN
//   defined   -> MULDIV decode, MD_WAIT state, md_req/md_abort/md_timeout/MD_Op live
//   undefined -> R-type with Funct7_0=1 decodes as NOP; mul/div outputs tied to 0
//
// Ports:
//   CLK, rst_n                 clock (rising edge), async active-low reset
//   in_valid / in_ready        upstream handshake for decoded instruction fields
//   opcode, Funct3, Funct7_5,
//   Funct7_0, undef_instr      instruction fields from the decoder
//   flush                      pipeline flush, highest priority
//   out_valid / out_ready      downstream handshake for the registered control word
//   ALU_Ctrl, Sub, Unsigned,
//   Shift_Right, Arith         control word (op class + mode bits)
//   MD_Op                      latched Funct3 for the mul/div unit
//   md_req / md_done           mul/div request level / result-ready pulse
//   md_abort                   one-cycle pulse on flush or timeout while waiting
//   md_timeout                 sticky timeout error, cleared only by reset
module alu_ctrl_seq #(
    parameter int unsigned ALU_CTRL_W = 4,
    parameter int unsigned MD_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 7
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            opcode,
    input  logic [2:0]            Funct3,
    input  logic                  Funct7_5,
    input  logic                  Funct7_0,
    input  logic                  undef_instr,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ALU_CTRL_W-1:0] ALU_Ctrl,
    output logic                  Sub,
    output logic                  Unsigned,
    output logic                  Shift_Right,
    output logic                  Arith,
    output logic [2:0]            MD_Op,
    output logic                  md_req,
    input  logic                  md_done,
    output logic                  md_abort,
    output logic                  md_timeout
);

    if (ALU_CTRL_W < 3 || MD_TIMEOUT < 2 || (2 ** CNT_W) <= MD_TIMEOUT) begin : g_bad_params
        $error("alu_ctrl_seq: illegal parameter combination");
    end

    localparam logic [ALU_CTRL_W-1:0] C_ADD    = ALU_CTRL_W'(0);
    localparam logic [ALU_CTRL_W-1:0] C_SLT    = ALU_CTRL_W'(1);
    localparam logic [ALU_CTRL_W-1:0] C_LOGIC  = ALU_CTRL_W'(2);
    localparam logic [ALU_CTRL_W-1:0] C_SHIFT  = ALU_CTRL_W'(3);
    localparam logic [ALU_CTRL_W-1:0] C_BRANCH = ALU_CTRL_W'(4);
    localparam logic [ALU_CTRL_W-1:0] C_PASSB  = ALU_CTRL_W'(5);
    localparam logic [ALU_CTRL_W-1:0] C_NOP    = '1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [0:0] {IDLE, MD_WAIT} state_t;

    typedef struct packed {
        logic [ALU_CTRL_W-1:0] alu;
        logic                  sub;
        logic                  uns;
        logic                  sr;
        logic                  ar;
    } ctrl_t;

    localparam ctrl_t NOP_WORD = '{alu: C_NOP, sub: 1'b0, uns: 1'b0, sr: 1'b0, ar: 1'b0};

    function automatic logic [ALU_CTRL_W-1:0] f3_class(input logic [2:0] f3);
        case (f3)
            3'b000:         return C_ADD;
            3'b010, 3'b011: return C_SLT;
            3'b001, 3'b101: return C_SHIFT;
            default:        return C_LOGIC;
        endcase
    endfunction

    state_t state_q, state_n;
    ctrl_t  word_q, word_n, dec;
    logic   out_valid_q, out_valid_n;
    logic   accept;

    // ---------------- decoder (combinational, from current inputs) -------------
`ifdef M_EXT_EN
    localparam logic [ALU_CTRL_W-1:0] C_MULDIV = ALU_CTRL_W'(6);
    logic dec_md;
`endif

    always_comb begin
        dec = NOP_WORD;
`ifdef M_EXT_EN
        dec_md = 1'b0;
`endif
        if (!undef_instr) begin
            case (opcode)
                OP_R: begin
                    if (!Funct7_0) begin
                        dec.alu = f3_class(Funct3);
                        dec.sub = (Funct3 == 3'b000) && Funct7_5;
                        dec.uns = (Funct3 == 3'b011);
                        dec.sr  = (Funct3 == 3'b101);
                        dec.ar  = (Funct3 == 3'b101) && Funct7_5;
                    end
`ifdef M_EXT_EN
                    else begin
                        dec.alu = C_MULDIV;
                        dec.uns = Funct3[2] && Funct3[0];  // DIVU / REMU
                        dec_md  = 1'b1;
                    end
`endif
                end
                OP_IMM: begin
                    dec.alu = f3_class(Funct3);
                    dec.uns = (Funct3 == 3'b011);
                    dec.sr  = (Funct3 == 3'b101);
                    dec.ar  = (Funct3 == 3'b101) && Funct7_5;
                end
                OP_BRANCH: begin
                    dec.alu = C_BRANCH;
                    dec.sub = 1'b1;
                    dec.uns = (Funct3[2:1] == 2'b11);
                end
                OP_LUI: dec.alu = C_PASSB;
                OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_AUIPC: dec.alu = C_ADD;
                default: dec = NOP_WORD;
            endcase
        end
    end

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // ---------------- sequencer ------------------------------------------------
`ifdef M_EXT_EN
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [2:0]       md_op_q, md_op_n;
    logic             md_req_q, md_req_n;
    logic             md_abort_q, md_abort_n;
    logic             md_to_q, md_to_n;
`else
    logic md_done_unused;
    assign md_done_unused = md_done;
`endif

    always_comb begin
        state_n     = state_q;
        word_n      = word_q;
        out_valid_n = out_valid_q;
`ifdef M_EXT_EN
        cnt_n       = cnt_q;
        md_op_n     = md_op_q;
        md_req_n    = md_req_q;
        md_abort_n  = 1'b0;
        md_to_n     = md_to_q;
`endif
        if (flush) begin
            state_n     = IDLE;
            out_valid_n = 1'b0;
`ifdef M_EXT_EN
            md_req_n    = 1'b0;
            md_abort_n  = (state_q == MD_WAIT);
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        word_n      = dec;
                        out_valid_n = 1'b1;
`ifdef M_EXT_EN
                        // The MULDIV word is latched now but only presented on completion.
                        if (dec_md) begin
                            out_valid_n = 1'b0;
                            state_n     = MD_WAIT;
                            md_req_n    = 1'b1;
                            md_op_n     = Funct3;
                            cnt_n       = '0;
                        end
`endif
                    end else if (out_ready) begin
                        out_valid_n = 1'b0;
                    end
                end
`ifdef M_EXT_EN
                MD_WAIT: begin
                    if (md_done) begin
                        state_n     = IDLE;
                        md_req_n    = 1'b0;
                        out_valid_n = 1'b1;
                    end else if (cnt_q == CNT_W'(MD_TIMEOUT - 1)) begin
                        state_n     = IDLE;
                        md_req_n    = 1'b0;
                        md_abort_n  = 1'b1;
                        md_to_n     = 1'b1;
                        word_n      = NOP_WORD;
                        out_valid_n = 1'b1;
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
`endif
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_q      <= NOP_WORD;
            out_valid_q <= 1'b0;
`ifdef M_EXT_EN
            cnt_q       <= '0;
            md_op_q     <= '0;
            md_req_q    <= 1'b0;
            md_abort_q  <= 1'b0;
            md_to_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_n;
            word_q      <= word_n;
            out_valid_q <= out_valid_n;
`ifdef M_EXT_EN
            cnt_q       <= cnt_n;
            md_op_q     <= md_op_n;
            md_req_q    <= md_req_n;
            md_abort_q  <= md_abort_n;
            md_to_q     <= md_to_n;
`endif
        end
    end

    assign out_valid   = out_valid_q;
    assign ALU_Ctrl    = word_q.alu;
    assign Sub         = word_q.sub;
    assign Unsigned    = word_q.uns;
    assign Shift_Right = word_q.sr;
    assign Arith       = word_q.ar;

`ifdef M_EXT_EN
    assign MD_Op      = md_op_q;
    assign md_req     = md_req_q;
    assign md_abort   = md_abort_q;
    assign md_timeout = md_to_q;
`else
    assign MD_Op      = '0;
    assign md_req     = 1'b0;
    assign md_abort   = 1'b0;
    assign md_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed self-checking bench for alu_ctrl_seq (default parameters).
// Covers both builds; M_EXT_EN selects the mul/div scenarios.
module tb_alu_ctrl_seq;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [6:0] opcode;
    logic [2:0] Funct3;
    logic       Funct7_5, Funct7_0, undef_instr, flush;
    logic       out_valid, out_ready;
    logic [3:0] ALU_Ctrl;
    logic       Sub, Unsigned, Shift_Right, Arith;
    logic [2:0] MD_Op;
    logic       md_req, md_done, md_abort, md_timeout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    alu_ctrl_seq #(.ALU_CTRL_W(4), .MD_TIMEOUT(64), .CNT_W(7)) dut (
        .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .Funct3(Funct3), .Funct7_5(Funct7_5), .Funct7_0(Funct7_0),
        .undef_instr(undef_instr), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .ALU_Ctrl(ALU_Ctrl), .Sub(Sub), .Unsigned(Unsigned),
        .Shift_Right(Shift_Right), .Arith(Arith), .MD_Op(MD_Op), .md_req(md_req),
        .md_done(md_done), .md_abort(md_abort), .md_timeout(md_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                         input logic f75, input logic f70, input logic undef);
        opcode      = op;
        Funct3      = f3;
        Funct7_5    = f75;
        Funct7_0    = f70;
        undef_instr = undef;
        in_valid    = 1'b1;
    endtask

    // {ALU_Ctrl, Sub, Unsigned, Shift_Right, Arith}
    function automatic logic [7:0] word();
        return {ALU_Ctrl, Sub, Unsigned, Shift_Right, Arith};
    endfunction

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f75;
        logic       undef;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [16];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs = '{
            '{OP_R,      3'b011, 1'b0, 1'b0, 8'h14},  // SLTU
            '{OP_IMM,    3'b100, 1'b0, 1'b0, 8'h20},  // XORI
            '{OP_R,      3'b001, 1'b0, 1'b0, 8'h30},  // SLL
            '{OP_R,      3'b101, 1'b0, 1'b0, 8'h32},  // SRL
            '{OP_R,      3'b101, 1'b1, 1'b0, 8'h33},  // SRA
            '{OP_IMM,    3'b000, 1'b1, 1'b0, 8'h00},  // ADDI, imm bit 30 set: no Sub
            '{OP_IMM,    3'b010, 1'b0, 1'b0, 8'h10},  // SLTI
            '{OP_BRANCH, 3'b111, 1'b0, 1'b0, 8'h4C},  // BGEU
            '{OP_BRANCH, 3'b100, 1'b0, 1'b0, 8'h48},  // BLT
            '{7'b0110111, 3'b000, 1'b0, 1'b0, 8'h50}, // LUI
            '{7'b0000011, 3'b010, 1'b0, 1'b0, 8'h00}, // LOAD
            '{7'b0100011, 3'b010, 1'b0, 1'b0, 8'h00}, // STORE
            '{7'b1101111, 3'b000, 1'b0, 1'b0, 8'h00}, // JAL
            '{7'b1100111, 3'b000, 1'b0, 1'b0, 8'h00}, // JALR
            '{7'b1111111, 3'b000, 1'b0, 1'b0, 8'hF0}, // unknown opcode
            '{OP_BRANCH, 3'b000, 1'b0, 1'b1, 8'hF0}   // undef_instr
        };

        rst_n = 1'b0; in_valid = 1'b0; opcode = '0; Funct3 = '0; Funct7_5 = 1'b0;
        Funct7_0 = 1'b0; undef_instr = 1'b0; flush = 1'b0; out_ready = 1'b0; md_done = 1'b0;
        tick(); tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_word", word(), 8'hF0);
        check("rst_md", {MD_Op, md_req, md_abort, md_timeout}, 6'h00);
        check("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        tick();

        // R-type SUB
        out_ready = 1'b1;
        drive(OP_R, 3'b000, 1'b1, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        check("sub_valid", out_valid, 1'b1);
        check("sub_word", word(), 8'h08);
        tick();
        check("sub_drain", out_valid, 1'b0);

        // SRAI held while out_ready low, competing input must not be taken
        out_ready = 1'b0;
        drive(OP_IMM, 3'b101, 1'b1, 1'b0, 1'b0);
        tick();
        drive(OP_IMM, 3'b000, 1'b0, 1'b0, 1'b0);
        check("srai_valid", out_valid, 1'b1);
        check("srai_word", word(), 8'h33);
        check("srai_in_ready", in_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("srai_hold_valid", out_valid, 1'b1);
            check("srai_hold_word", word(), 8'h33);
            check("srai_hold_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check("srai_release_in_ready", in_ready, 1'b1);
        tick();
        check("srai_drain", out_valid, 1'b0);

        // Back-to-back decode table
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].op, vecs[i].f3, vecs[i].f75, 1'b0, vecs[i].undef);
            tick();
            check($sformatf("dec%0d_valid", i), out_valid, 1'b1);
            check($sformatf("dec%0d_word", i), word(), vecs[i].exp);
        end
        in_valid = 1'b0; undef_instr = 1'b0;
        tick();
        check("dec_drain", out_valid, 1'b0);

        // Flush in IDLE beats pending word and simultaneous accept
        out_ready = 1'b0;
        drive(OP_R, 3'b000, 1'b0, 1'b0, 1'b0);
        tick();
        check("flush_pre_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        flush = 1'b1;
        drive(OP_IMM, 3'b100, 1'b0, 1'b0, 1'b0);
        tick();
        check("flush_idle_valid", out_valid, 1'b0);
        check("flush_idle_abort", md_abort, 1'b0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check("flush_idle_no_accept", out_valid, 1'b0);

`ifdef M_EXT_EN
        // DIVU, md_done after 5 request cycles
        drive(OP_R, 3'b101, 1'b0, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        check("divu_req", md_req, 1'b1);
        check("divu_md_op", MD_Op, 3'b101);
        check("divu_wait_valid", out_valid, 1'b0);
        check("divu_wait_in_ready", in_ready, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("divu_req_hold", md_req, 1'b1);
        end
        md_done = 1'b1;
        tick();
        md_done = 1'b0;
        check("divu_done_req", md_req, 1'b0);
        check("divu_done_valid", out_valid, 1'b1);
        check("divu_done_word", word(), 8'h64);
        check("divu_done_in_ready", in_ready, 1'b1);
        tick();
        check("divu_drain", out_valid, 1'b0);

        // md_done in IDLE ignored
        md_done = 1'b1;
        tick();
        md_done = 1'b0;
        check("idle_done_valid", out_valid, 1'b0);
        check("idle_done_req", md_req, 1'b0);

        // MUL timeout
        begin
            int hi = 0;
            drive(OP_R, 3'b000, 1'b0, 1'b1, 1'b0);
            tick();
            in_valid = 1'b0;
            for (int k = 0; k < 63; k++) begin
                if (md_req && !md_abort) hi++;
                tick();
            end
            check("mul_req_cycles", hi, 63);
            check("mul_pre_timeout_req", md_req, 1'b1);
            check("mul_pre_timeout_flag", md_timeout, 1'b0);
        end
        tick();
        check("mul_to_abort", md_abort, 1'b1);
        check("mul_to_flag", md_timeout, 1'b1);
        check("mul_to_req", md_req, 1'b0);
        check("mul_to_valid", out_valid, 1'b1);
        check("mul_to_word", word(), 8'hF0);
        check("mul_to_in_ready", in_ready, 1'b1);
        tick();
        check("mul_to_abort_pulse", md_abort, 1'b0);
        check("mul_to_sticky", md_timeout, 1'b1);

        // md_done coincident with timeout: done wins
        drive(OP_R, 3'b000, 1'b0, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 63; k++) tick();
        md_done = 1'b1;
        tick();
        md_done = 1'b0;
        check("race_valid", out_valid, 1'b1);
        check("race_word", word(), 8'h60);
        check("race_abort", md_abort, 1'b0);
        tick();

        // Flush on 2nd MD_WAIT cycle with simultaneous in_valid
        drive(OP_R, 3'b101, 1'b0, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        drive(OP_R, 3'b000, 1'b0, 1'b0, 1'b0);
        tick();
        check("mdflush_req", md_req, 1'b0);
        check("mdflush_abort", md_abort, 1'b1);
        check("mdflush_valid", out_valid, 1'b0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check("mdflush_abort_pulse", md_abort, 1'b0);
        check("mdflush_no_accept", out_valid, 1'b0);

        // Reset mid-MD_WAIT
        drive(OP_R, 3'b000, 1'b0, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("mdrst_md", {MD_Op, md_req, md_abort, md_timeout}, 6'h00);
        check("mdrst_in_ready", in_ready, 1'b1);
        check("mdrst_word", word(), 8'hF0);
        tick();
        rst_n = 1'b1;
        tick();
`else
        // Without M extension: MUL and DIVU decode as NOP, no request
        drive(OP_R, 3'b000, 1'b0, 1'b1, 1'b0);
        tick();
        check("nom_mul_valid", out_valid, 1'b1);
        check("nom_mul_word", word(), 8'hF0);
        check("nom_mul_req", md_req, 1'b0);
        drive(OP_R, 3'b101, 1'b0, 1'b1, 1'b0);
        md_done = 1'b1;
        tick();
        md_done = 1'b0;
        in_valid = 1'b0;
        check("nom_divu_word", word(), 8'hF0);
        check("nom_md", {MD_Op, md_req, md_abort, md_timeout}, 6'h00);
        check("nom_in_ready", in_ready, 1'b1);
        tick();
        check("nom_drain", out_valid, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
